// File: rtl/mips_dmem_resp.sv
// Data-memory responder for the MIPS core: posted stores go into a small FIFO
// that drains into word RAM on idle cycles, with youngest-entry load forwarding.
module mips_dmem_resp #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WBUF_DEPTH  = 4,
    parameter logic [31:0] DONE_ADDR   = 32'd84,
    parameter logic [31:0] DONE_DATA   = 32'd7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          memwrite,
    input  logic [31:0]                   dataadr,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
    output logic                          err_misaligned,
    output logic                          err_range,
    output logic                          err_overflow,
    output logic [15:0]                   store_count,
    output logic                          done
);

    localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
    localparam int PTR_BITS  = $clog2(WBUF_DEPTH);
    localparam int CNT_BITS  = PTR_BITS + 1;

    logic [31:0]          r_ram     [DEPTH_WORDS];
    logic [ADDR_BITS-1:0] r_wb_idx  [WBUF_DEPTH];
    logic [31:0]          r_wb_data [WBUF_DEPTH];

    logic [PTR_BITS-1:0]  r_head;
    logic [PTR_BITS-1:0]  r_tail;
    logic [CNT_BITS-1:0]  r_count;
    logic                 r_err_misaligned;
    logic                 r_err_range;
    logic                 r_err_overflow;
    logic [15:0]          r_store_count;
    logic                 r_done;

    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_in_range;
    logic                 w_aligned;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_drain;
    logic                 w_done_hit;

    logic [PTR_BITS-1:0]  w_slot_age  [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] w_slot_live;
    logic [WBUF_DEPTH-1:0] w_slot_hit;
    logic                 w_fwd_hit;
    logic [31:0]          w_fwd_data;
    logic [PTR_BITS-1:0]  w_slot;

    assign w_idx      = dataadr[ADDR_BITS+1:2];
    assign w_in_range = (dataadr[31:ADDR_BITS+2] == '0);
    assign w_aligned  = (dataadr[1:0] == 2'b00);
    assign w_full     = (r_count == CNT_BITS'(WBUF_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_accept   = memwrite & w_aligned & w_in_range & ~w_full;
    // Any cycle with memwrite high blocks the drain, even a rejected store.
    assign w_drain    = ~memwrite & ~w_empty;
    assign w_done_hit = w_accept && (dataadr == DONE_ADDR) && (writedata == DONE_DATA);

    // Age 0 is the head (oldest); a slot is live when its age is below the count.
    generate
        for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_slot
            assign w_slot_age[gi]  = PTR_BITS'(gi) - r_head;
            assign w_slot_live[gi] = ({1'b0, w_slot_age[gi]} < r_count);
            assign w_slot_hit[gi]  = w_slot_live[gi] && (r_wb_idx[gi] == w_idx);
        end
    endgenerate

    // Walk oldest to youngest so the youngest matching entry is the one kept.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_slot     = '0;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            w_slot = r_head + PTR_BITS'(k);
            if (w_slot_hit[w_slot]) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_wb_data[w_slot];
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (w_in_range) begin
            readdata = w_fwd_hit ? w_fwd_data : r_ram[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wb_idx[r_tail]  <= w_idx;
            r_wb_data[r_tail] <= writedata;
        end
    end

    // Whole-word write gated by a count that reset forces to zero, so no torn words.
    always_ff @(posedge clk) begin
        if (w_drain) begin
            r_ram[r_wb_idx[r_head]] <= r_wb_data[r_head];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_err_misaligned <= 1'b0;
            r_err_range      <= 1'b0;
            r_err_overflow   <= 1'b0;
            r_store_count    <= '0;
            r_done           <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tail  <= r_tail + 1'b1;
                r_count <= r_count + 1'b1;
                if (r_store_count != 16'hFFFF) begin
                    r_store_count <= r_store_count + 16'd1;
                end
            end else if (w_drain) begin
                r_head  <= r_head + 1'b1;
                r_count <= r_count - 1'b1;
            end

            if (!w_in_range) begin
                r_err_range <= 1'b1;
            end
            if (memwrite && !w_aligned) begin
                r_err_misaligned <= 1'b1;
            end
            if (memwrite && w_full) begin
                r_err_overflow <= 1'b1;
            end
            if (w_done_hit) begin
                r_done <= 1'b1;
            end
        end
    end

    assign wbuf_count     = r_count;
    assign err_misaligned = r_err_misaligned;
    assign err_range      = r_err_range;
    assign err_overflow   = r_err_overflow;
    assign store_count    = r_store_count;
    assign done           = r_done;

endmodule

// File: doc/mips_dmem_resp.md
Name: mips_dmem_resp

Overview:
Memory-side responder for the MIPS data-memory interface. It accepts processor stores (memwrite, dataadr, writedata) into a small posted write buffer, then drains the buffer into a word-addressed RAM during idle cycles. It returns readdata with forwarding from the buffer. It also raises sticky error flags, counts stores, and detects the test-program completion store. It sits opposite the processor's data port and is shared by the RTL top and the UVM environment.

Parameters:
DEPTH_WORDS, 64, number of 32-bit RAM words; power of two; ADDR_BITS = log2(DEPTH_WORDS)
WBUF_DEPTH, 4, posted write-buffer entries; power of two, minimum 2
DONE_ADDR, 32'd84, byte address of the completion store
DONE_DATA, 32'd7, data value of the completion store

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
memwrite  input  1  store request, sampled on the rising edge
dataadr  input  32  byte address for load or store
writedata  input  32  store data
readdata  output  32  load data, combinational from dataadr
wbuf_count  output  log2(WBUF_DEPTH)+1  entries currently in the write buffer
err_misaligned  output  1  sticky; a store had dataadr[1:0] != 0
err_range  output  1  sticky; a store or read had dataadr >= 4*DEPTH_WORDS
err_overflow  output  1  sticky; a store arrived while the buffer was full
store_count  output  16  number of accepted stores, saturating
done  output  1  sticky; the completion store has been accepted

Behaviour:
- Reset (reset low, asynchronous):
  - Write buffer emptied; wbuf_count = 0.
  - All err_* = 0, store_count = 0, done = 0.
  - RAM is not reset; it keeps its contents. Buffered entries are discarded, not drained.
- Word index = dataadr[ADDR_BITS+1:2]. In range means dataadr < 4*DEPTH_WORDS.
- Store acceptance at a rising edge with memwrite = 1. The store is accepted only if all hold:
  - dataadr[1:0] == 0
  - dataadr is in range
  - wbuf_count < WBUF_DEPTH
- Accepted store:
  - Entry {index, writedata} pushed at the FIFO tail; wbuf_count increments.
  - store_count increments, saturating at 16'hFFFF.
- Rejected store: dropped, no buffer change. Every applicable flag is set in the same edge:
  - err_misaligned if dataadr[1:0] != 0
  - err_range if out of range
  - err_overflow if the buffer is full
- Drain:
  - At a rising edge with memwrite = 0 and wbuf_count > 0, the head entry is written to RAM and popped; wbuf_count decrements.
  - One entry drains per idle cycle, in FIFO order, so the last write to an address wins.
  - No drain happens on any cycle with memwrite = 1, including rejected stores.
  - Push and pop never happen in the same cycle.
- readdata is combinational and independent of memwrite:
  - Out of range: readdata = 0 and err_range is set at the next edge.
  - In range: the youngest buffer entry whose index matches is forwarded; otherwise RAM[index] is returned.
  - dataadr[1:0] is ignored for reads.
  - A store accepted at edge N is visible on readdata immediately after edge N.
- done:
  - Set at the edge that accepts a store with dataadr == DONE_ADDR and writedata == DONE_DATA.
  - Stays high until reset.
  - A rejected matching store does not set it.
- Sticky flags and done are cleared only by reset.
- Latency:
  - Store to readdata visibility: 0 cycles after the accepting edge.
  - Store to RAM: k+1 idle cycles, where k is the number of entries ahead of it.
- Boundaries:
  - Full buffer plus memwrite: rejected with err_overflow; no stall signal exists.
  - Address 4*DEPTH_WORDS-4: valid.
  - Address 4*DEPTH_WORDS: range error.
  - Reset asserted mid-drain: the partially completed drain has either fully written its RAM word or not written it at all. No torn words.

Test Plan:
- Directed scenarios:
  - Reset, then store 32'hDEADBEEF to 0x10 and hold memwrite = 0 → readdata 32'hDEADBEEF right after the edge; wbuf_count 1→0 after one idle cycle; store_count = 1.
  - Five back-to-back stores to 0x0,0x4,0x8,0xC,0x10 (data 1..5) → first four accepted; fifth rejected; err_overflow = 1; store_count = 4; after four idle cycles RAM words 0..3 read back 1..4; 0x10 reads the old RAM value.
  - Store 0xA then 0xB to 0x20 back-to-back → readdata 0xB before and after draining.
  - Store to 0x13 → err_misaligned = 1, store_count unchanged. Store to 0x100 with DEPTH_WORDS = 64 → err_range = 1, readdata = 0.
  - Store 7 to address 84 → done = 1 after the edge. Store 7 to 84 while full → done stays 0.
  - Reset asserted with wbuf_count = 3 → wbuf_count 0 and all flags 0 immediately; RAM shows none of the discarded entries.
- Coverage points: full, empty, forward hit, forward miss, and drain-blocked cycles.
